// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between the ID stage (master) and the ID/EXE pipeline register (slave).
interface pipe_stage_reg_if #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// ID/EXE pipeline register: 2-entry in-order head+skid buffer with flush,
// load-use bubble injection and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int                DATA_W    = 101,
  parameter int                CTRL_W    = 6,
  parameter logic [CTRL_W-1:0] KILL_MASK = 6'b100101,
  parameter int                CNT_W     = 16
) (
  input  logic             clk,
  input  logic             clr,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  input  logic             bubble,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        occ_q, occ_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pop_s;
  logic              push_s;
  logic              inject_s;
  logic              enq_s;
  logic              space_s;
  logic [DATA_W-1:0] enq_data_s;
  logic [CTRL_W-1:0] enq_ctrl_s;

  assign bus.in_ready  = (occ_q < 2'd2) && !bubble && !clr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_data_q;
  assign bus.out_ctrl  = head_ctrl_q;
  assign occupancy     = occ_q;
  assign bubble_cnt    = cnt_q;

  // A bubble may use the slot freed by a same-cycle pop; a real push may not.
  always_comb begin
    pop_s    = out_valid_q && bus.out_ready;
    space_s  = (occ_q < 2'd2) || pop_s;
    inject_s = bubble && !flush && space_s;
    push_s   = bus.in_valid && bus.in_ready && !flush;
    enq_s    = inject_s || push_s;
    if (inject_s) begin
      enq_data_s = {DATA_W{1'b0}};
      enq_ctrl_s = bus.in_ctrl & ~KILL_MASK;
    end else begin
      enq_data_s = bus.in_data;
      enq_ctrl_s = bus.in_ctrl;
    end
  end

  // Next-state for buffer contents, occupancy and bubble counter.
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    cnt_d       = cnt_q;

    if (flush) begin
      occ_d       = 2'd0;
      head_data_d = {DATA_W{1'b0}};
      head_ctrl_d = {CTRL_W{1'b0}};
      skid_data_d = {DATA_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
    end else begin
      case ({enq_s, pop_s})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_data_d = enq_data_s;
            head_ctrl_d = enq_ctrl_s;
            occ_d       = 2'd1;
          end else begin
            skid_data_d = enq_data_s;
            skid_ctrl_d = enq_ctrl_s;
            occ_d       = 2'd2;
          end
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            occ_d       = 2'd1;
          end else begin
            occ_d       = 2'd0;
          end
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            skid_data_d = enq_data_s;
            skid_ctrl_d = enq_ctrl_s;
            occ_d       = 2'd2;
          end else begin
            head_data_d = enq_data_s;
            head_ctrl_d = enq_ctrl_s;
            occ_d       = 2'd1;
          end
        end
        default: begin
          occ_d = occ_q;
        end
      endcase
    end

    if (inject_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    out_valid_d = (occ_d != 2'd0);
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      occ_q       <= 2'd0;
      out_valid_q <= 1'b0;
      head_data_q <= {DATA_W{1'b0}};
      head_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed stimulus queues expected heads,
// a negedge monitor pops and compares every consumed head.
module tb_pipe_stage_reg;
  localparam int DW = 101;
  localparam int CW = 6;
  localparam int EW = DW + CW;

  logic clk = 1'b0;
  logic clr;
  logic flush;
  logic bubble;
  logic [1:0]  occ;
  logic [15:0] cnt;
  logic        flush2;
  logic        bubble2;
  logic [1:0]  occ2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] sb[$];

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus2 ();

  pipe_stage_reg dut (
    .clk(clk), .clr(clr), .bus(bus), .flush(flush), .bubble(bubble),
    .occupancy(occ), .bubble_cnt(cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .bus(bus2), .flush(flush2), .bubble(bubble2),
    .occupancy(occ2), .bubble_cnt(cnt2)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic [DW-1:0] d, input logic [CW-1:0] c);
    return {d, c};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ctrl  = c;
    sb.push_back(mk(d, c));
    step();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every head consumed by EXE must match the oldest expected entry.
  always @(negedge clk) begin
    if (!clr && !flush && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: got %0h expected no entry", {bus.out_data, bus.out_ctrl});
      end else begin
        logic [EW-1:0] e;
        e = sb.pop_front();
        if ({bus.out_data, bus.out_ctrl} !== e) begin
          n_bad++;
          $display("FAIL sb_head: got %0h expected %0h", {bus.out_data, bus.out_ctrl}, e);
        end
      end
    end
  end

  initial begin
    clr = 1'b1; flush = 1'b0; bubble = 1'b0;
    flush2 = 1'b0; bubble2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_ctrl = '0; bus2.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_occ", occ, 2'd0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ctrl", bus.out_ctrl, 0);
    chk("rst_cnt", cnt, 0);
    clr = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    step();

    // Streaming at full rate.
    bus.out_ready = 1'b1;
    push_in(101'h11, 6'h01);
    chk("stream_occ1", occ, 2'd1);
    chk("stream_data1", bus.out_data, 8'h11);
    push_in(101'h22, 6'h02);
    chk("stream_occ2", occ, 2'd1);
    chk("stream_data2", bus.out_data, 8'h22);
    push_in(101'h33, 6'h03);
    chk("stream_occ3", occ, 2'd1);
    chk("stream_data3", bus.out_data, 8'h33);
    step();
    chk("stream_drain_occ", occ, 2'd0);

    // Backpressure fills both slots and holds the head.
    bus.out_ready = 1'b0;
    push_in(101'hA, 6'h0A);
    push_in(101'hB, 6'h0B);
    chk("bp_occ", occ, 2'd2);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_hold", bus.out_data, 8'h0A);
    step();
    chk("bp_hold2", bus.out_data, 8'h0A);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_next_head", bus.out_data, 8'h0B);
    chk("bp_occ_after_pop", occ, 2'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_drain_occ", occ, 2'd0);

    // Bubble at empty; in_valid stays high and must not be consumed.
    bus.in_valid = 1'b1; bus.in_data = 101'h55; bus.in_ctrl = 6'b111111;
    bubble = 1'b1;
    #1;
    chk("bub_in_ready", bus.in_ready, 1'b0);
    sb.push_back(mk(101'h0, 6'b011010));
    step();
    bubble = 1'b0; bus.in_valid = 1'b0;
    chk("bub_ctrl", bus.out_ctrl, 6'b011010);
    chk("bub_data", bus.out_data, 0);
    chk("bub_cnt", cnt, 16'd1);
    chk("bub_occ", occ, 2'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bub_drain_occ", occ, 2'd0);

    // Bubble pends while full, then injects alongside a pop.
    push_in(101'h1, 6'h11);
    push_in(101'h2, 6'h12);
    bus.in_ctrl = 6'b000111;
    bubble = 1'b1;
    step();
    chk("pend_occ", occ, 2'd2);
    chk("pend_cnt", cnt, 16'd1);
    bus.out_ready = 1'b1;
    sb.push_back(mk(101'h0, 6'b000010));
    step();
    bubble = 1'b0;
    chk("pend_inj_occ", occ, 2'd2);
    chk("pend_inj_cnt", cnt, 16'd2);
    chk("pend_head", bus.out_data, 8'h02);
    step();
    step();
    bus.out_ready = 1'b0;
    chk("pend_drain_occ", occ, 2'd0);

    // Flush when full, with a concurrent upstream entry.
    push_in(101'h3, 6'h13);
    push_in(101'h4, 6'h14);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 101'hC; bus.in_ctrl = 6'h1C;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    chk("flush_occ", occ, 2'd0);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_cnt", cnt, 16'd2);
    bus.out_ready = 1'b1;
    step();
    chk("flush_stays_empty", occ, 2'd0);

    // Flush at occupancy 1 overrides a same-cycle push and pop.
    bus.out_ready = 1'b0;
    push_in(101'h5, 6'h15);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 101'hD; bus.in_ctrl = 6'h1D;
    bus.out_ready = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    sb.delete();
    chk("flush_push_occ", occ, 2'd0);
    chk("flush_push_valid", bus.out_valid, 1'b0);

    // Reset mid-stream with a full buffer.
    push_in(101'h6, 6'h16);
    push_in(101'h7, 6'h17);
    clr = 1'b1;
    step();
    clr = 1'b0;
    sb.delete();
    chk("mid_rst_occ", occ, 2'd0);
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_ctrl", bus.out_ctrl, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_cnt", cnt, 0);
    push_in(101'h8, 6'h18);
    chk("mid_rst_first", bus.out_data, 8'h08);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Saturating counter on the narrow instance.
    bus2.out_ready = 1'b1;
    bus2.in_ctrl = 6'b111111;
    bubble2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      step();
      chk("sat_cnt", cnt2, exp_cnt);
    end
    bubble2 = 1'b0;
    chk("sat_occ", occ2, 2'd1);
    step();
    step();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
